// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// The JALR/JALLINK states are only reachable when CTRL_JALR_EN is defined.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11,
        S_JALR     = 4'd12,
        S_JALLINK  = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp, funct3, funct7b5 and op[5] to alu_control.
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                // funct7b5 only means sub for register-register ops; addi ignores it
                case (funct3)
                    3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main Moore control FSM for the multicycle RV32I core with memory-ready handshake.
// Optional JALR support is enabled by defining CTRL_JALR_EN.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       mem_req,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_instr
);

    state_t  state, next_state;
    alu_op_t alu_op;
    logic    pc_update, branch;
    logic    ir_write_d, mem_write_d, reg_write_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= state_t'(RESET_STATE);
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_d    = 1'b0;
        mem_write_d   = 1'b0;
        reg_write_d   = 1'b0;
        adr_src       = 1'b0;
        mem_req       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RD2;
        imm_src       = IMM_I;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write_d = 1'b1;
                    pc_update  = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECUTER;
                    OP_I:              next_state = S_EXECUTEI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
`ifdef CTRL_JALR_EN
                    OP_JALR:           next_state = S_JALR;
`endif
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_IMM;
                imm_src    = op[5] ? IMM_S : IMM_I;
                next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_d = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req     = 1'b1;
                adr_src     = 1'b1;
                mem_write_d = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_RD2;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_RD2;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                imm_src    = IMM_J;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
`ifdef CTRL_JALR_EN
            S_JALR: begin
                alu_src_a  = SRC_A_RD1;
                alu_src_b  = SRC_B_IMM;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
                next_state = S_JALLINK;
            end
            S_JALLINK: begin
                alu_src_a   = SRC_A_OLDPC;
                alu_src_b   = SRC_B_FOUR;
                result_src  = RES_ALURESULT;
                reg_write_d = 1'b1;
                next_state  = S_FETCH;
            end
`endif
            S_TRAP: begin
                illegal_instr = 1'b1;
            end
            default: next_state = state_t'(RESET_STATE);
        endcase
    end

    // Write enables are gated by reset so nothing commits while reset is held.
    assign pc_write  = ~reset & (pc_update | (branch & (zero ^ funct3[0])));
    assign ir_write  = ~reset & ir_write_d;
    assign mem_write = ~reset & mem_write_d;
    assign reg_write = ~reset & reg_write_d;

    multicycle_control_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule
